// File: rtl/byte_mem_pkg.sv
// Shared encodings and lane helpers for the byte-addressable memory controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package byte_mem_pkg;

  // Access size encodings on req_size.
  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  // Controller FSM state encodings.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  // True when `lane` of the addressed row is touched by the access.
  // A word covers lanes off..BPW-1 of the first row; a byte covers only lane off.
  function automatic logic lane_first(input logic size, input int unsigned off,
                                      input int unsigned lane);
    if (size == SZ_WORD) return (lane >= off);
    return (lane == off);
  endfunction

  // True when `lane` of the following row carries the tail of a misaligned word.
  function automatic logic lane_second(input int unsigned off, input int unsigned lane);
    return (lane < off);
  endfunction

  // Bit distance a lane offset moves data between word order and row order.
  function automatic int unsigned rot_bits(input int unsigned off,
                                           input int unsigned byte_width);
    return off * byte_width;
  endfunction

endpackage

// File: rtl/byte_mem_array.sv
// Row storage: ROWS rows of WORD_WIDTH bits, one synchronous row access per cycle.
// Latency: read data appears the cycle after the enabled edge and holds until the next one.
// Backpressure: none; the caller issues at most one row access per cycle.
module byte_mem_array
  import byte_mem_pkg::*;
#(
  parameter int ROWS       = 512,
  parameter int WORD_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  localparam int BPW       = WORD_WIDTH / BYTE_WIDTH,
  localparam int ROW_W     = $clog2(ROWS)
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic [BPW-1:0]        lane_we,
  input  logic [ROW_W-1:0]      row,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [ROWS];

  // Byte-enabled write plus registered read of the same row; contents are never reset.
  always_ff @(posedge clock) begin
    if (en) begin
      for (int k = 0; k < BPW; k++) begin
        if (lane_we[k]) begin
          mem[row][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      rdata <= mem[row];
    end
  end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Byte-addressable little-endian memory: byte/word access, misaligned split, range errors.
// Latency: 1 cycle for byte/aligned/error accesses, 2 cycles for a misaligned word.
// Backpressure: req_ready drops for exactly one cycle while a misaligned word's second row runs.
module byte_mem_ctrl
  import byte_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic                  req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int BPW   = WORD_WIDTH / BYTE_WIDTH;
  localparam int ROWS  = DEPTH / BPW;
  localparam int OFF_W = $clog2(BPW);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN_X  = (ADDR_WIDTH+1)'(BPW - 1);

  logic [0:0]              state;
  logic                    accept;
  logic                    is_word;
  logic                    range_err;
  logic                    misaligned;
  logic [OFF_W-1:0]        req_off;
  logic [ROW_W-1:0]        req_row;
  logic [ADDR_WIDTH:0]     addr_x;
  logic [ADDR_WIDTH:0]     last_x;
  logic [WORD_WIDTH-1:0]   wdata_sel;
  logic [2*WORD_WIDTH-1:0] wdata_rot;
  logic [BPW-1:0]          mask_first;
  logic [BPW-1:0]          mask_second;

  // Context for the second row of a misaligned word.
  logic [ROW_W-1:0]        sec_row;
  logic [BPW-1:0]          sec_mask;
  logic [WORD_WIDTH-1:0]   sec_wdata;
  logic                    sec_wr;
  logic [OFF_W-1:0]        sec_off;

  // Context describing how to format the array output into rsp_rdata.
  logic                    rsp_zero;
  logic                    rsp_word;
  logic                    rsp_split;
  logic [OFF_W-1:0]        rsp_off;
  logic [WORD_WIDTH-1:0]   first_row;
  logic [WORD_WIDTH-1:0]   hold_rdata;
  logic [WORD_WIDTH-1:0]   rsp_cat;
  logic [WORD_WIDTH-1:0]   rsp_fmt;

  logic                    arr_en;
  logic [BPW-1:0]          arr_we;
  logic [ROW_W-1:0]        arr_row;
  logic [WORD_WIDTH-1:0]   arr_wdata;
  logic [WORD_WIDTH-1:0]   arr_rdata;

  // Request decode; reset blocks acceptance so no storage write happens while it is held.
  assign req_ready  = (state == ST_IDLE);
  assign accept     = req_valid && req_ready && !reset;
  assign is_word    = (req_size == SZ_WORD);
  assign req_off    = req_addr[OFF_W-1:0];
  assign req_row    = req_addr[OFF_W +: ROW_W];
  assign addr_x     = {1'b0, req_addr};
  assign last_x     = addr_x + SPAN_X;
  assign range_err  = (addr_x >= DEPTH_X) || (is_word && (last_x >= DEPTH_X));
  assign misaligned = is_word && (req_off != '0);
  assign wdata_sel  = is_word ? req_wdata
                              : {{(WORD_WIDTH-BYTE_WIDTH){1'b0}}, req_wdata[BYTE_WIDTH-1:0]};
  // Low half lands in the addressed row, high half is the spill into the next row.
  assign wdata_rot  = {{WORD_WIDTH{1'b0}}, wdata_sel} << rot_bits(32'(req_off), BYTE_WIDTH);

  // Lane enables for the addressed row and for the spill row.
  always_comb begin
    mask_first  = '0;
    mask_second = '0;
    for (int k = 0; k < BPW; k++) begin
      mask_first[k]  = lane_first(req_size, 32'(req_off), k);
      mask_second[k] = lane_second(32'(req_off), k);
    end
  end

  // Steer the single array port: the spill row has priority over new requests.
  always_comb begin
    arr_en    = 1'b0;
    arr_we    = '0;
    arr_row   = req_row;
    arr_wdata = wdata_rot[WORD_WIDTH-1:0];
    if (state == ST_SECOND) begin
      arr_en    = 1'b1;
      arr_row   = sec_row;
      arr_wdata = sec_wdata;
      arr_we    = sec_wr ? sec_mask : '0;
    end else if (accept && !range_err) begin
      arr_en = 1'b1;
      arr_we = req_wr ? mask_first : '0;
    end
  end

  byte_mem_array #(
    .ROWS       (ROWS),
    .WORD_WIDTH (WORD_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_array (
    .clock   (clock),
    .en      (arr_en),
    .lane_we (arr_we),
    .row     (arr_row),
    .wdata   (arr_wdata),
    .rdata   (arr_rdata)
  );

  // FSM and response bookkeeping; a reset during SECOND drops the pending spill row.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_zero   <= 1'b1;
      rsp_word   <= 1'b0;
      rsp_split  <= 1'b0;
      rsp_off    <= '0;
      sec_row    <= '0;
      sec_mask   <= '0;
      sec_wdata  <= '0;
      sec_wr     <= 1'b0;
      sec_off    <= '0;
      first_row  <= '0;
      hold_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == ST_SECOND) begin
        state     <= ST_IDLE;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_zero  <= sec_wr;
        rsp_word  <= 1'b1;
        rsp_split <= 1'b1;
        rsp_off   <= sec_off;
        first_row <= arr_rdata;
      end else if (accept) begin
        if (misaligned && !range_err) begin
          state      <= ST_SECOND;
          sec_row    <= req_row + ROW_W'(1);
          sec_mask   <= mask_second;
          sec_wdata  <= wdata_rot[2*WORD_WIDTH-1:WORD_WIDTH];
          sec_wr     <= req_wr;
          sec_off    <= req_off;
          hold_rdata <= rsp_fmt;
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= range_err;
          rsp_zero  <= req_wr || range_err;
          rsp_word  <= is_word;
          rsp_split <= 1'b0;
          rsp_off   <= req_off;
        end
      end
    end
  end

  // Rotate {next row, first row} back into word order and size it.
  assign rsp_cat = WORD_WIDTH'({arr_rdata, (rsp_split ? first_row : arr_rdata)}
                               >> rot_bits(32'(rsp_off), BYTE_WIDTH));

  // Writes, errors and reset present zero; byte reads are zero-extended.
  always_comb begin
    rsp_fmt = '0;
    if (!rsp_zero) begin
      rsp_fmt = rsp_word ? rsp_cat
                         : {{(WORD_WIDTH-BYTE_WIDTH){1'b0}}, rsp_cat[BYTE_WIDTH-1:0]};
    end
  end

  // While the first row of a split read is in flight the array output moves, so show the held value.
  assign rsp_rdata = (state == ST_SECOND) ? hold_rdata : rsp_fmt;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Self-checking bench for byte_mem_ctrl against a byte-array reference model.
// Latency: checks response timing of 1 or 2 cycles after acceptance.
// Backpressure: checks req_ready drops for exactly one cycle on a misaligned word.
module tb_byte_mem_ctrl;

  localparam int ADDR_WIDTH = 16;
  localparam int DEPTH      = 1024;
  localparam int BYTE_WIDTH = 8;
  localparam int WORD_WIDTH = 16;
  localparam int BPW        = WORD_WIDTH / BYTE_WIDTH;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_wr = 1'b0;
  logic                  req_size = 1'b0;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic [WORD_WIDTH-1:0] req_wdata = '0;
  logic                  rsp_valid;
  logic [WORD_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  always #5 clock = ~clock;

  byte_mem_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  int n_vec = 0;
  int n_bad = 0;
  int ncyc  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain byte array plus a queue of expected responses.
  typedef struct {
    int                    due;
    logic [WORD_WIDTH-1:0] data;
    logic                  err;
  } exp_t;

  logic [BYTE_WIDTH-1:0] mem_m [DEPTH];
  exp_t                  expq[$];
  logic [WORD_WIDTH-1:0] last_data = '0;
  logic                  last_err  = 1'b0;

  // Response monitor: every pulse must match the next expected response at the right cycle,
  // and outputs must hold the last response's values between pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        last_data = '0;
        last_err  = 1'b0;
      end else if (rsp_valid) begin
        if (expq.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = expq.pop_front();
          check("rsp_cycle", ncyc, e.due);
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          last_data = e.data;
          last_err  = e.err;
        end
      end else begin
        check("hold_rdata", 32'(rsp_rdata), 32'(last_data));
        check("hold_err", 32'(rsp_err), 32'(last_err));
      end
      ncyc++;
    end
  end

  task automatic idle();
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Present one request, wait for acceptance, and record what the model says it should return.
  task automatic send(input logic wr, input logic sz, input int addr,
                      input logic [WORD_WIDTH-1:0] wd);
    exp_t e;
    int   acc;
    int   guard;
    int   nb;
    bit   err;
    bit   mis;
    @(negedge clock);
    req_valid = 1'b1;
    req_wr    = wr;
    req_size  = sz;
    req_addr  = ADDR_WIDTH'(addr);
    req_wdata = wd;
    check("req_ready", 32'(req_ready), 1);
    guard = 0;
    while (!req_ready && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    acc = ncyc;
    nb  = sz ? BPW : 1;
    err = (addr >= DEPTH) || (sz && (addr + BPW - 1 >= DEPTH));
    mis = sz && !err && (addr % BPW != 0);
    e.due  = acc + (mis ? 1 : 0);
    e.err  = err;
    e.data = '0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        if (wr) mem_m[addr+i] = wd[i*BYTE_WIDTH +: BYTE_WIDTH];
        else    e.data[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_m[addr+i];
      end
    end
    expq.push_back(e);
    if (mis) begin
      @(negedge clock);
      check("ready_low", 32'(req_ready), 0);
      // Garbage while stalled must be ignored.
      req_wr    = 1'($urandom);
      req_size  = 1'($urandom);
      req_addr  = ADDR_WIDTH'($urandom);
      req_wdata = WORD_WIDTH'($urandom);
    end
  endtask

  initial begin
    int guard;
    int a;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;

    // Fill every row so the model knows all contents.
    for (int r = 0; r < DEPTH / BPW; r++) send(1'b1, 1'b1, r * BPW, WORD_WIDTH'($urandom));
    idle();

    // 1: aligned word write/read, byte read of upper lane.
    send(1'b1, 1'b1, 0, 16'hBEEF);
    send(1'b0, 1'b1, 0, 16'h0000);
    send(1'b0, 1'b0, 1, 16'h0000);
    idle();
    // 2: byte write over a word, lane 0 untouched.
    send(1'b1, 1'b1, 2, 16'h1234);
    send(1'b1, 1'b0, 3, 16'hFF5A);
    send(1'b0, 1'b1, 2, 16'h0000);
    idle();
    // 3: misaligned word write/read and neighbour bytes.
    send(1'b1, 1'b1, 5, 16'hA1B2);
    send(1'b0, 1'b1, 5, 16'h0000);
    send(1'b0, 1'b0, 5, 16'h0000);
    send(1'b0, 1'b0, 6, 16'h0000);
    send(1'b0, 1'b0, 4, 16'h0000);
    send(1'b0, 1'b0, 7, 16'h0000);
    idle();
    // 4: out-of-range accesses, then no wrap into row 0.
    send(1'b0, 1'b1, DEPTH - 1, 16'h0000);
    send(1'b1, 1'b0, DEPTH, 16'h00EE);
    send(1'b1, 1'b1, DEPTH - 1, 16'h7777);
    send(1'b0, 1'b0, 0, 16'h0000);
    send(1'b0, 1'b0, DEPTH - 1, 16'h0000);
    idle();
    // 5: back-to-back aligned reads.
    send(1'b0, 1'b1, 0, 16'h0000);
    send(1'b0, 1'b1, 2, 16'h0000);
    send(1'b0, 1'b1, 4, 16'h0000);
    idle();

    // 6: reset pulsed during the second row of a misaligned write.
    send(1'b1, 1'b0, 10, 16'h0077);
    idle();
    guard = 0;
    while (expq.size() != 0 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    @(negedge clock);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_size  = 1'b1;
    req_addr  = ADDR_WIDTH'(9);
    req_wdata = 16'hCCDD;
    check("t6_ready", 32'(req_ready), 1);
    @(posedge clock);
    mem_m[9] = 8'hDD;  // first-row lane commits at acceptance; byte 10 must keep 0x77
    @(negedge clock);
    req_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("t6_rsp_valid", 32'(rsp_valid), 0);
    check("t6_rsp_rdata", 32'(rsp_rdata), 0);
    check("t6_rsp_err", 32'(rsp_err), 0);
    check("t6_req_ready", 32'(req_ready), 1);
    @(negedge clock);
    #2 reset = 1'b0;
    send(1'b0, 1'b0, 9, 16'h0000);
    send(1'b0, 1'b0, 10, 16'h0000);
    send(1'b0, 1'b1, 9, 16'h0000);
    idle();

    // Randomized traffic, biased toward the top boundary.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) a = int'($urandom_range(DEPTH - 3, DEPTH + 2));
      else                            a = int'($urandom_range(0, DEPTH - 1));
      send(1'($urandom), 1'($urandom), a, WORD_WIDTH'($urandom));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    guard = 0;
    while (expq.size() != 0 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check("drain", 32'(expq.size()), 0);
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, miscompares so far %0d", n_bad);
    $fatal(1);
  end

endmodule
